rlc_decoder: RTL and testbench

//  Run-length decoder for 8x8 quantized JPEG coefficient blocks; inverse of the run-length encoder stage.

---
 rtl/rlc_decoder.sv | 185 ++++++++++++++++++
 tb/tb_rlc_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rlc_decoder.sv
// Run-length decoder for 8x8 quantized JPEG blocks.
// Takes a DC symbol followed by zigzag-ordered AC (run, level) symbols and rebuilds the
// 64 coefficients in raster order. The finished block is presented on a valid/ready port.
module rlc_decoder #(
  parameter int unsigned W       = 11,
  parameter bit          DC_DIFF = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_pred,
  input  logic            sym_valid,
  output logic            sym_ready,
  input  logic [3:0]      sym_run,
  input  logic [W-1:0]    sym_level,
  output logic            blk_valid,
  input  logic            blk_ready,
  output logic [64*W-1:0] blk_coef,
  output logic            blk_err
);

  typedef enum logic [1:0] {SDc, SAc, SOut} state_e;

  // Zigzag position -> raster index (standard JPEG order)
  localparam logic [5:0] ZzRaster [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_e         state_q, state_d;
  logic           rdy_en_q;
  logic [6:0]     pos_q, pos_d;
  logic           err_q, err_d;
  logic [W-1:0]   dc_pred_q, dc_pred_d;
  logic [W-1:0]   coef_q [64];

  logic           accept;
  logic           is_eob, is_zrl;
  logic [6:0]     pos_zrl, pos_run;
  logic [W-1:0]   dc_base, dc_sat, dc_val;
  logic [W:0]     dc_sum;
  logic           wr_en, clr_buf;
  logic [5:0]     wr_zz;
  logic [W-1:0]   wr_val;

  assign accept  = sym_valid && sym_ready;
  assign is_eob  = (sym_run == 4'd0)  && (sym_level == '0);
  assign is_zrl  = (sym_run == 4'd15) && (sym_level == '0);
  // pos <= 63 and run <= 15, so 7 bits never wrap
  assign pos_zrl = pos_q + 7'd16;
  assign pos_run = pos_q + {3'b000, sym_run};

  // DC reconstruction: predictor + difference, widened by one bit then saturated
  always_comb begin
    dc_base = clr_pred ? '0 : dc_pred_q;
    dc_sum  = {dc_base[W-1], dc_base} + {sym_level[W-1], sym_level};
    if (dc_sum[W] != dc_sum[W-1]) begin
      dc_sat = dc_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      dc_sat = dc_sum[W-1:0];
    end
    dc_val = DC_DIFF ? dc_sat : sym_level;
  end

  // State register; rdy_en_q holds sym_ready low for the first cycle out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SDc;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SDc: if (accept) state_d = SAc;
      SAc: begin
        if (accept) begin
          if (is_eob) begin
            state_d = SOut;
          end else if (is_zrl) begin
            if (pos_zrl >= 7'd64) state_d = SOut;
          end else if (pos_run >= 7'd63) begin
            state_d = SOut;
          end
        end
      end
      SOut: if (blk_ready) state_d = SDc;
      default: state_d = SDc;
    endcase
  end

  // FSM outputs
  always_comb begin
    sym_ready = rdy_en_q && (state_q != SOut);
    blk_valid = (state_q == SOut);
    blk_err   = err_q;
  end

  // Datapath next-state: position, error flag, predictor and buffer write
  always_comb begin
    pos_d     = pos_q;
    err_d     = err_q;
    dc_pred_d = clr_pred ? '0 : dc_pred_q;
    wr_en     = 1'b0;
    wr_zz     = 6'd0;
    wr_val    = sym_level;
    clr_buf   = 1'b0;
    unique case (state_q)
      SDc: begin
        if (accept) begin
          wr_en     = 1'b1;
          wr_val    = dc_val;
          pos_d     = 7'd1;
          dc_pred_d = dc_val;
        end
      end
      SAc: begin
        if (accept && !is_eob) begin
          if (is_zrl) begin
            pos_d = pos_zrl;
            if (pos_zrl > 7'd64) err_d = 1'b1;
          end else if (pos_run <= 7'd63) begin
            wr_en = 1'b1;
            wr_zz = pos_run[5:0];
            pos_d = pos_run + 7'd1;
          end else begin
            // Run overflows the block: symbol is dropped
            err_d = 1'b1;
          end
        end
      end
      SOut: begin
        if (blk_ready) begin
          clr_buf = 1'b1;
          pos_d   = 7'd0;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q     <= 7'd0;
      err_q     <= 1'b0;
      dc_pred_q <= '0;
    end else begin
      pos_q     <= pos_d;
      err_q     <= err_d;
      dc_pred_q <= dc_pred_d;
    end
  end

  // Coefficient buffer in raster order; cleared at handoff so skipped positions read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 64; k++) coef_q[k] <= '0;
    end else if (clr_buf) begin
      for (int k = 0; k < 64; k++) coef_q[k] <= '0;
    end else if (wr_en) begin
      coef_q[ZzRaster[wr_zz]] <= wr_val;
    end
  end

  // Flatten buffer onto the output bus, coefficient 0 at the MSBs
  always_comb begin
    blk_coef = '0;
    for (int k = 0; k < 64; k++) begin
      blk_coef[64*W-1-W*k -: W] = coef_q[k];
    end
  end

endmodule

// File: tb/tb_rlc_decoder.sv
// Directed testbench for rlc_decoder with hand-computed expected blocks.
module tb_rlc_decoder;

  localparam int W  = 11;
  localparam int BW = 64 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_pred;
  logic          sym_valid;
  logic          sym_ready;
  logic [3:0]    sym_run;
  logic [W-1:0]  sym_level;
  logic          blk_valid;
  logic          blk_ready;
  logic [BW-1:0] blk_coef;
  logic          blk_err;

  int n_checks = 0;
  int n_pass   = 0;

  rlc_decoder #(.W(W), .DC_DIFF(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_pred  (clr_pred),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_run   (sym_run),
    .sym_level (sym_level),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_coef  (blk_coef),
    .blk_err   (blk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Place value v at raster index k of a block image
  function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int k,
                                        input logic [W-1:0] v);
    b[BW-1-W*k -: W] = v;
    return b;
  endfunction

  // Present one symbol from a negedge; returns on the negedge after it is accepted
  task automatic send(input logic [3:0] r, input logic [W-1:0] l);
    int n = 0;
    sym_valid = 1'b1;
    sym_run   = r;
    sym_level = l;
    while (!sym_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 1'b0, 1'b1);
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic chk_blk(input string tag, input logic [BW-1:0] exp, input logic exp_err);
    check({tag, "_valid"}, blk_valid, 1'b1);
    check({tag, "_coef"}, blk_coef, exp);
    check({tag, "_err"}, blk_err, exp_err);
  endtask

  task automatic handoff(input string tag);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    check({tag, "_after_handoff"}, blk_valid, 1'b0);
  endtask

  logic [BW-1:0] exp;

  initial begin
    rst_n = 1'b0; clr_pred = 1'b0; sym_valid = 1'b0; sym_run = '0; sym_level = '0;
    blk_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", sym_ready, 1'b0);
    check("rst_valid", blk_valid, 1'b0);
    check("rst_err", blk_err, 1'b0);
    check("rst_coef", blk_coef, '0);
    rst_n = 1'b1;
    #1 check("ready_held_low", sym_ready, 1'b0);
    @(negedge clk);
    check("ready_after_rst", sym_ready, 1'b1);

    // 1: DC=+5, EOB
    send(4'd0, 11'sd5);
    check("t1_no_early_valid", blk_valid, 1'b0);
    send(4'd0, 11'd0);
    chk_blk("t1", put('0, 0, 11'd5), 1'b0);
    handoff("t1");

    // 2: DC=-3 (5-3=2), (1,7) -> zz2 = r8, EOB
    send(4'd0, -11'sd3);
    send(4'd1, 11'd7);
    send(4'd0, 11'd0);
    exp = put(put('0, 0, 11'd2), 8, 11'd7);
    chk_blk("t2", exp, 1'b0);
    handoff("t2");

    // 3: ZRL x3 then (14,-1) -> p=63 implicit end
    send(4'd0, 11'd0);
    send(4'd15, 11'd0);
    send(4'd15, 11'd0);
    send(4'd15, 11'd0);
    check("t3_not_done", blk_valid, 1'b0);
    send(4'd14, -11'sd1);
    exp = put(put('0, 0, 11'd2), 63, 11'h7FF);
    chk_blk("t3", exp, 1'b0);
    handoff("t3");

    // 4: ZRL x3 then (15,4) -> p=64 overflow, dropped
    send(4'd0, 11'd0);
    send(4'd15, 11'd0);
    send(4'd15, 11'd0);
    send(4'd15, 11'd0);
    send(4'd15, 11'd4);
    chk_blk("t4", put('0, 0, 11'd2), 1'b1);
    handoff("t4");

    // 5: next block clean error; then stall with blk_ready low
    send(4'd0, 11'd1);
    send(4'd0, 11'd0);
    exp = put('0, 0, 11'd3);
    chk_blk("t5", exp, 1'b0);
    sym_valid = 1'b1; sym_run = 4'd0; sym_level = 11'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_stall_ready", sym_ready, 1'b0);
      check("t5_stall_coef", blk_coef, exp);
    end
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    check("t5_handoff_valid", blk_valid, 1'b0);
    check("t5_handoff_ready", sym_ready, 1'b1);
    @(negedge clk);
    sym_valid = 1'b0;
    check("t5_dc_taken", blk_valid, 1'b0);
    send(4'd0, 11'd0);
    chk_blk("t5b", put('0, 0, 11'd12), 1'b0);
    handoff("t5b");

    // ZRL landing exactly on 64: (14,2) -> zz15 = r5, then ZRL x3
    send(4'd0, 11'd0);
    send(4'd14, 11'd2);
    send(4'd15, 11'd0);
    send(4'd15, 11'd0);
    check("zrl64_not_done", blk_valid, 1'b0);
    send(4'd15, 11'd0);
    chk_blk("zrl64", put(put('0, 0, 11'd12), 5, 11'd2), 1'b0);
    handoff("zrl64");

    // 6: saturation, clr_pred with DC, clr_pred alone
    send(4'd0, 11'd1008);
    send(4'd0, 11'd0);
    chk_blk("pred1020", put('0, 0, 11'd1020), 1'b0);
    handoff("pred1020");
    send(4'd0, 11'd10);
    send(4'd0, 11'd0);
    chk_blk("sat", put('0, 0, 11'd1023), 1'b0);
    handoff("sat");
    clr_pred = 1'b1;
    send(4'd0, 11'd4);
    clr_pred = 1'b0;
    send(4'd0, 11'd0);
    chk_blk("clr_dc", put('0, 0, 11'd4), 1'b0);
    handoff("clr_dc");
    clr_pred = 1'b1;
    @(negedge clk);
    clr_pred = 1'b0;
    send(4'd0, 11'd6);
    send(4'd0, 11'd0);
    chk_blk("clr_alone", put('0, 0, 11'd6), 1'b0);
    handoff("clr_alone");

    // Reset mid-AC discards the partial block and the predictor
    send(4'd0, 11'd3);
    send(4'd2, 11'd5);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", sym_ready, 1'b0);
    check("midrst_valid", blk_valid, 1'b0);
    check("midrst_err", blk_err, 1'b0);
    check("midrst_coef", blk_coef, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_block", blk_valid, 1'b0);
    send(4'd0, 11'd7);
    send(4'd0, 11'd0);
    chk_blk("after_rst", put('0, 0, 11'd7), 1'b0);
    handoff("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
